ipv4_header_scheduler: RTL and testbench

Round-robin scheduler that shares one combinational IPv4 header checksum unit among NUM_REQ header requesters. It accepts a winning requester's header fields, drives them to the external checksum unit for one cycle, registers the result, and emits the complete 20-byte IPv4 header as five 32-bit beats on a valid/ready stream. It sits between the per-flow packet builders and the accelerator's transmit framer.

---
 rtl/ipv4_header_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_ipv4_header_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_header_scheduler.sv
// ipv4_header_scheduler
// Round-robin arbiter that shares one external combinational IPv4 checksum
// unit among NUM_REQ header requesters and streams each finished 20-byte
// header as five 32-bit beats on a valid/ready interface.
//
// Optional build macro IPV4_SCHED_TTL_DROP_EN:
//   When defined, headers granted with TTL == 0 are consumed without being
//   emitted, and a saturating 16-bit drop_count output is present.
//   When undefined, TTL is not inspected and drop_count does not exist.
module ipv4_header_scheduler #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*136-1:0] req_fields,
  output logic [7:0]             ck_version,
  output logic [7:0]             ck_service_type,
  output logic [15:0]            ck_length,
  output logic [15:0]            ck_identification,
  output logic [15:0]            ck_flags_and_fragment,
  output logic [7:0]             ck_ttl,
  output logic [7:0]             ck_protocol,
  output logic [31:0]            ck_src_ip_address,
  output logic [31:0]            ck_dst_ip_address,
  input  logic [15:0]            ck_checksum,
  output logic [31:0]            hdr_data,
  output logic                   hdr_valid,
  input  logic                   hdr_ready,
  output logic                   hdr_last,
  output logic [2:0]             hdr_src
`ifdef IPV4_SCHED_TTL_DROP_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CSUM = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t        state_r;
  logic [2:0]    rr_ptr_r;
  logic [135:0]  fld_r;
  logic [7:0]    ck_version_r;
  logic [2:0]    hdr_src_r;
  logic [15:0]   csum_r;
  logic [2:0]    beat_r;
  logic [31:0]   hdr_data_r;
  logic          hdr_valid_r;
  logic          hdr_last_r;
`ifdef IPV4_SCHED_TTL_DROP_EN
  logic [15:0]   drop_count_r;
`endif

  logic [7:0]    valid_pad_s;
  logic [3:0]    sum_s;
  logic [2:0]    winner_s;
  logic          any_valid_s;
  logic [2:0]    next_ptr_s;
  logic [135:0]  sel_fields_s;

  // Header word for a given beat index, built from the latched fields.
  function automatic logic [31:0] beat_word(input logic [2:0] idx,
                                            input logic [135:0] f,
                                            input logic [15:0] csum);
    logic [31:0] w;
    case (idx)
      3'd0:    w = {8'h45, f[135:128], f[127:112]};
      3'd1:    w = {f[111:96], f[95:80]};
      3'd2:    w = {f[79:72], f[71:64], csum};
      3'd3:    w = f[63:32];
      3'd4:    w = f[31:0];
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    valid_pad_s = 8'h00;
    valid_pad_s[NUM_REQ-1:0] = req_valid;
    winner_s    = rr_ptr_r;
    any_valid_s = 1'b0;
    sum_s       = 4'd0;
    // Walk offsets from farthest to nearest so the nearest valid one wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum_s = {1'b0, rr_ptr_r} + 4'(k);
      sum_s = (sum_s >= 4'(NUM_REQ)) ? (sum_s - 4'(NUM_REQ)) : sum_s;
      winner_s    = valid_pad_s[sum_s[2:0]] ? sum_s[2:0] : winner_s;
      any_valid_s = valid_pad_s[sum_s[2:0]] | any_valid_s;
    end
    next_ptr_s = (winner_s == 3'(NUM_REQ - 1)) ? 3'd0 : (winner_s + 3'd1);
  end

  // Select the winner's field slice.
  always_comb begin
    sel_fields_s = 136'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_fields_s = (winner_s == 3'(i)) ? req_fields[136*i +: 136] : sel_fields_s;
    end
  end

  // One-hot accept strobe, only in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_r == IDLE) && any_valid_s && rst_n && (winner_s == 3'(i))) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Scheduler FSM: grant, sample checksum, stream five header beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      rr_ptr_r     <= 3'd0;
      fld_r        <= 136'd0;
      ck_version_r <= 8'h00;
      hdr_src_r    <= 3'd0;
      csum_r       <= 16'h0000;
      beat_r       <= 3'd0;
      hdr_data_r   <= 32'h0000_0000;
      hdr_valid_r  <= 1'b0;
      hdr_last_r   <= 1'b0;
`ifdef IPV4_SCHED_TTL_DROP_EN
      drop_count_r <= 16'h0000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (any_valid_s) begin
            fld_r        <= sel_fields_s;
            ck_version_r <= 8'h45;
            hdr_src_r    <= winner_s;
            rr_ptr_r     <= next_ptr_s;
            state_r      <= CSUM;
          end else begin
            state_r      <= IDLE;
          end
        end
        CSUM: begin
          csum_r <= ck_checksum;
          beat_r <= 3'd0;
`ifdef IPV4_SCHED_TTL_DROP_EN
          if (fld_r[79:72] == 8'h00) begin
            state_r <= IDLE;
            if (drop_count_r != 16'hFFFF) begin
              drop_count_r <= drop_count_r + 16'd1;
            end
          end else begin
            hdr_data_r  <= beat_word(3'd0, fld_r, ck_checksum);
            hdr_valid_r <= 1'b1;
            hdr_last_r  <= 1'b0;
            state_r     <= EMIT;
          end
`else
          hdr_data_r  <= beat_word(3'd0, fld_r, ck_checksum);
          hdr_valid_r <= 1'b1;
          hdr_last_r  <= 1'b0;
          state_r     <= EMIT;
`endif
        end
        EMIT: begin
          if (hdr_ready) begin
            if (beat_r == 3'd4) begin
              hdr_valid_r <= 1'b0;
              hdr_last_r  <= 1'b0;
              hdr_data_r  <= 32'h0000_0000;
              beat_r      <= 3'd0;
              state_r     <= IDLE;
            end else begin
              beat_r      <= beat_r + 3'd1;
              hdr_data_r  <= beat_word(beat_r + 3'd1, fld_r, csum_r);
              hdr_last_r  <= (beat_r == 3'd3);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          hdr_valid_r <= 1'b0;
          hdr_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ck_version            = ck_version_r;
  assign ck_service_type       = fld_r[135:128];
  assign ck_length             = fld_r[127:112];
  assign ck_identification     = fld_r[111:96];
  assign ck_flags_and_fragment = fld_r[95:80];
  assign ck_ttl                = fld_r[79:72];
  assign ck_protocol           = fld_r[71:64];
  assign ck_src_ip_address     = fld_r[63:32];
  assign ck_dst_ip_address     = fld_r[31:0];
  assign hdr_data              = hdr_data_r;
  assign hdr_valid             = hdr_valid_r;
  assign hdr_last              = hdr_last_r;
  assign hdr_src               = hdr_src_r;
`ifdef IPV4_SCHED_TTL_DROP_EN
  assign drop_count            = drop_count_r;
`endif

endmodule

// File: tb/tb_ipv4_header_scheduler.sv
// Directed self-checking bench for ipv4_header_scheduler (NUM_REQ = 4).
// The checksum unit is modelled here as a real IPv4 one's-complement sum.
module tb_ipv4_header_scheduler;

  localparam int NUM_REQ = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid = 4'b0000;
  logic [3:0]   req_ready;
  logic [543:0] req_fields = 544'd0;
  logic [7:0]   ck_version, ck_service_type, ck_ttl, ck_protocol;
  logic [15:0]  ck_length, ck_identification, ck_flags_and_fragment;
  logic [31:0]  ck_src_ip_address, ck_dst_ip_address;
  logic [15:0]  ck_checksum;
  logic [31:0]  hdr_data;
  logic         hdr_valid;
  logic         hdr_ready = 1'b1;
  logic         hdr_last;
  logic [2:0]   hdr_src;
`ifdef IPV4_SCHED_TTL_DROP_EN
  logic [15:0]  drop_count;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  ipv4_header_scheduler #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_fields(req_fields),
    .ck_version(ck_version), .ck_service_type(ck_service_type),
    .ck_length(ck_length), .ck_identification(ck_identification),
    .ck_flags_and_fragment(ck_flags_and_fragment), .ck_ttl(ck_ttl),
    .ck_protocol(ck_protocol), .ck_src_ip_address(ck_src_ip_address),
    .ck_dst_ip_address(ck_dst_ip_address), .ck_checksum(ck_checksum),
    .hdr_data(hdr_data), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_last(hdr_last), .hdr_src(hdr_src)
`ifdef IPV4_SCHED_TTL_DROP_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ip_csum(input logic [7:0] ver, input logic [7:0] st,
                                          input logic [15:0] len, input logic [15:0] id,
                                          input logic [15:0] ff, input logic [7:0] ttl,
                                          input logic [7:0] proto, input logic [31:0] src,
                                          input logic [31:0] dst);
    logic [31:0] s;
    s = 32'({ver, st}) + 32'(len) + 32'(id) + 32'(ff) + 32'({ttl, proto})
      + 32'(src[31:16]) + 32'(src[15:0]) + 32'(dst[31:16]) + 32'(dst[15:0]);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    return ~s[15:0];
  endfunction

  // Checksum unit stub driven from the scheduler's CK outputs.
  assign ck_checksum = ip_csum(ck_version, ck_service_type, ck_length, ck_identification,
                               ck_flags_and_fragment, ck_ttl, ck_protocol,
                               ck_src_ip_address, ck_dst_ip_address);

  function automatic logic [135:0] mk(input logic [7:0] st, input logic [15:0] len,
                                      input logic [15:0] id, input logic [15:0] ff,
                                      input logic [7:0] ttl, input logic [7:0] proto,
                                      input logic [31:0] src, input logic [31:0] dst);
    return {st, len, id, ff, ttl, proto, src, dst};
  endfunction

  // Expected five beats packed MSB-first: beat b at [159-32*b -: 32].
  function automatic logic [159:0] exp_words(input logic [135:0] f);
    logic [15:0] c;
    c = ip_csum(8'h45, f[135:128], f[127:112], f[111:96], f[95:80],
                f[79:72], f[71:64], f[63:32], f[31:0]);
    return {8'h45, f[135:128], f[127:112], f[111:96], f[95:80],
            f[79:72], f[71:64], c, f[63:32], f[31:0]};
  endfunction

  function automatic logic [135:0] rr_fields(input int i);
    return mk(8'(i), 16'h0100 + 16'(i), 16'h1000 + 16'(i), 16'h0000, 8'h20 + 8'(i),
              8'h06, 32'h0A00_0000 + 32'(i), 32'h0A00_00FF - 32'(i));
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 4'b0000;
    hdr_ready = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [135:0] f);
    req_fields[136*i +: 136] = f;
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp, output int gcyc);
    #1;
    for (int k = 0; k < 20 && req_ready == 4'b0000; k++) step();
    check_val({tag, "_grant"}, 32'(req_ready), 32'(exp));
    gcyc = cyc;
  endtask

  // Receive one header; optionally hold hdr_ready low before beat stall_beat.
  task automatic expect_header(input string tag, input logic [159:0] w, input logic [2:0] src,
                               input int stall_beat, input int stall_len, input int gcyc);
    for (int k = 0; k < 20 && !hdr_valid; k++) step();
    check_val({tag, "_valid"}, 32'(hdr_valid), 32'd1);
    check_val({tag, "_latency"}, 32'(cyc - gcyc), 32'd2);
    for (int b = 0; b < 5; b++) begin
      if (b == stall_beat) begin
        hdr_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check_val($sformatf("%s_stall%0d_valid", tag, s), 32'(hdr_valid), 32'd1);
          check_val($sformatf("%s_stall%0d_data", tag, s), hdr_data, w[159-32*b -: 32]);
          check_val($sformatf("%s_stall%0d_last", tag, s), 32'(hdr_last), 32'd0);
          step();
        end
        hdr_ready = 1'b1;
      end
      check_val($sformatf("%s_b%0d_data", tag, b), hdr_data, w[159-32*b -: 32]);
      check_val($sformatf("%s_b%0d_last", tag, b), 32'(hdr_last), 32'(b == 4));
      check_val($sformatf("%s_b%0d_src", tag, b), 32'(hdr_src), 32'(src));
      step();
    end
    check_val({tag, "_done"}, 32'(hdr_valid), 32'd0);
  endtask

  logic [135:0] f1;
  logic [135:0] f2;
  int g;
  int prev_g;

  initial begin
    f1 = mk(8'h00, 16'h0073, 16'h0000, 16'h4000, 8'h40, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7);
    f2 = mk(8'h2E, 16'h0054, 16'hBEEF, 16'h0000, 8'h80, 8'h01, 32'h0102_0304, 32'h0506_0708);

    // Reset values, observed while reset is held.
    step();
    req_valid = 4'b0001;
    #1;
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_hdr_valid", 32'(hdr_valid), 32'd0);
    check_val("rst_hdr_last", 32'(hdr_last), 32'd0);
    check_val("rst_hdr_data", hdr_data, 32'd0);
    check_val("rst_hdr_src", 32'(hdr_src), 32'd0);
    check_val("rst_ck_version", 32'(ck_version), 32'd0);
    check_val("rst_ck_length", 32'(ck_length), 32'd0);
    req_valid = 4'b0000;
    do_reset();

    // Single header with the reference vector.
    set_req(0, f1);
    req_valid = 4'b0001;
    wait_grant("t1", 4'b0001, g);
    step();
    req_valid = 4'b0000;
    check_val("t1_csum_ready", 32'(req_ready), 32'd0);
    check_val("t1_csum_valid", 32'(hdr_valid), 32'd0);
    check_val("t1_ck_version", 32'(ck_version), 32'h45);
    check_val("t1_ck_ttl", 32'(ck_ttl), 32'h40);
    check_val("t1_ck_src", ck_src_ip_address, 32'hC0A8_0001);
    check_val("t1_ck_sum", 32'(ck_checksum), 32'hB861);
    expect_header("t1", {32'h4500_0073, 32'h0000_4000, 32'h4011_B861,
                         32'hC0A8_0001, 32'hC0A8_00C7}, 3'd0, 7, 0, g);

    // All four requesters valid: order 0,1,2,3,0 at one header per 7 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, rr_fields(i));
    req_valid = 4'b1111;
    prev_g = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant($sformatf("rr%0d", n), 4'b0001 << (n % 4), g);
      if (n > 0) check_val($sformatf("rr%0d_period", n), 32'(g - prev_g), 32'd7);
      prev_g = g;
      step();
      if (n == 4) req_valid = 4'b0000;
      expect_header($sformatf("rr%0d", n), exp_words(rr_fields(n % 4)), 3'(n % 4), 7, 0, g);
    end

    // Backpressure: hdr_ready low for 3 cycles while beat 2 is presented.
    do_reset();
    set_req(0, f1);
    req_valid = 4'b0001;
    wait_grant("bp", 4'b0001, g);
    step();
    req_valid = 4'b0000;
    expect_header("bp", exp_words(f1), 3'd0, 2, 3, g);

    // Reset during beat 3, then requester 0 wins immediately with new data.
    do_reset();
    set_req(2, rr_fields(2));
    req_valid = 4'b0100;
    wait_grant("rs", 4'b0100, g);
    step();
    req_valid = 4'b0000;
    repeat (4) step();
    check_val("rs_b3_data", hdr_data, rr_fields(2) >> 32);
    check_val("rs_b3_src", 32'(hdr_src), 32'd2);
    rst_n = 1'b0;
    req_valid = 4'b0100;
    #1;
    check_val("rs_valid", 32'(hdr_valid), 32'd0);
    check_val("rs_last", 32'(hdr_last), 32'd0);
    check_val("rs_data", hdr_data, 32'd0);
    check_val("rs_src", 32'(hdr_src), 32'd0);
    check_val("rs_ck_src", ck_src_ip_address, 32'd0);
    check_val("rs_ck_version", 32'(ck_version), 32'd0);
    check_val("rs_ready", 32'(req_ready), 32'd0);
    repeat (2) step();
    set_req(0, f2);
    req_valid = 4'b1001;
    rst_n = 1'b1;
    wait_grant("rs_after", 4'b0001, g);
    step();
    req_valid = 4'b0000;
    expect_header("rs_after", exp_words(f2), 3'd0, 7, 0, g);

    // Pointer wrap: grant 3 alone, then 0 beats 3.
    do_reset();
    set_req(3, rr_fields(3));
    req_valid = 4'b1000;
    wait_grant("wr3", 4'b1000, g);
    step();
    req_valid = 4'b0000;
    expect_header("wr3", exp_words(rr_fields(3)), 3'd3, 7, 0, g);
    set_req(0, f2);
    req_valid = 4'b1001;
    wait_grant("wr0", 4'b0001, g);
    step();
    req_valid = 4'b0000;
    expect_header("wr0", exp_words(f2), 3'd0, 7, 0, g);

    // TTL == 0 handling.
    do_reset();
    set_req(0, mk(8'h00, 16'h0020, 16'h0001, 16'h0000, 8'h00, 8'h11, 32'h0A00_0001, 32'h0A00_0002));
    set_req(1, mk(8'h00, 16'h0020, 16'h0002, 16'h0000, 8'h01, 8'h11, 32'h0A00_0001, 32'h0A00_0002));
`ifdef IPV4_SCHED_TTL_DROP_EN
    check_val("drop_init", 32'(drop_count), 32'd0);
    req_valid = 4'b0001;
    wait_grant("drop", 4'b0001, g);
    step();
    req_valid = 4'b0000;
    check_val("drop_csum_valid", 32'(hdr_valid), 32'd0);
    step();
    check_val("drop_idle_valid", 32'(hdr_valid), 32'd0);
    check_val("drop_count", 32'(drop_count), 32'd1);
    req_valid = 4'b0010;
    wait_grant("ttl1", 4'b0010, g);
    step();
    req_valid = 4'b0000;
    expect_header("ttl1", exp_words(req_fields[136 +: 136]), 3'd1, 7, 0, g);
    check_val("drop_count_after", 32'(drop_count), 32'd1);
`else
    req_valid = 4'b0001;
    wait_grant("ttl0", 4'b0001, g);
    step();
    req_valid = 4'b0000;
    expect_header("ttl0", exp_words(req_fields[0 +: 136]), 3'd0, 7, 0, g);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
